// File: rtl/common_pkg.sv
// Shared widths and the control-word layout used by the integer issue path.
package common;
  parameter int PRF_WIDTH = 6;
  parameter int ROB_WIDTH = 5;

  typedef logic [PRF_WIDTH-1:0] prf_tag_t;
  typedef logic [ROB_WIDTH:0]   rob_id_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [1:0] src_sel;
    logic       is_branch;
    logic       is_word;
  } control_type;
endpackage

// File: rtl/int_issue_queue_if.sv
// Dispatch, wakeup, issue and flush signals between the rename stage and the integer issue queue.
interface int_issue_queue_if;
  import common::*;

  logic        instr0_valid_intisq, instr1_valid_intisq;
  control_type instr0_control, instr1_control;
  prf_tag_t    instr0_T, instr1_T;
  prf_tag_t    instr0_src1, instr0_src2, instr1_src1, instr1_src2;
  logic        isq_src1_busy_0, isq_src2_busy_0, isq_src1_busy_1, isq_src2_busy_1;
  rob_id_t     isq_robid_0, isq_robid_1;
  logic [1:0]  intisq_left;
  logic        wb0_valid, wb1_valid;
  prf_tag_t    wb0_tag, wb1_tag;
  logic        issue_ready;
  logic        issue_valid;
  control_type issue_control;
  prf_tag_t    issue_T, issue_src1, issue_src2;
  rob_id_t     issue_robid;
  logic        flush_valid;

  modport slave (
    input  instr0_valid_intisq, instr1_valid_intisq, instr0_control, instr1_control,
           instr0_T, instr1_T, instr0_src1, instr0_src2, instr1_src1, instr1_src2,
           isq_src1_busy_0, isq_src2_busy_0, isq_src1_busy_1, isq_src2_busy_1,
           isq_robid_0, isq_robid_1, wb0_valid, wb1_valid, wb0_tag, wb1_tag,
           issue_ready, flush_valid,
    output intisq_left, issue_valid, issue_control, issue_T, issue_src1, issue_src2, issue_robid
  );

  modport master (
    output instr0_valid_intisq, instr1_valid_intisq, instr0_control, instr1_control,
           instr0_T, instr1_T, instr0_src1, instr0_src2, instr1_src1, instr1_src2,
           isq_src1_busy_0, isq_src2_busy_0, isq_src1_busy_1, isq_src2_busy_1,
           isq_robid_0, isq_robid_1, wb0_valid, wb1_valid, wb0_tag, wb1_tag,
           issue_ready, flush_valid,
    input  intisq_left, issue_valid, issue_control, issue_T, issue_src1, issue_src2, issue_robid
  );
endinterface

// File: rtl/int_issue_queue.sv
// Collapsing integer issue queue: oldest entry at index 0, dual dispatch at the tail,
// tag-broadcast wakeup and oldest-ready single issue.
module int_issue_queue
  import common::*;
#(
  parameter int INTISQ_DEPTH = 8
) (
  input logic              clk,
  input logic              reset_n,
  int_issue_queue_if.slave bus
);
  localparam int IW = $clog2(INTISQ_DEPTH);
  localparam int CW = IW + 1;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [IW-1:0] idx_t;

  control_type ctrl_q [INTISQ_DEPTH];
  control_type ctrl_d [INTISQ_DEPTH];
  prf_tag_t    t_q    [INTISQ_DEPTH];
  prf_tag_t    t_d    [INTISQ_DEPTH];
  prf_tag_t    s1_q   [INTISQ_DEPTH];
  prf_tag_t    s1_d   [INTISQ_DEPTH];
  prf_tag_t    s2_q   [INTISQ_DEPTH];
  prf_tag_t    s2_d   [INTISQ_DEPTH];
  rob_id_t     rob_q  [INTISQ_DEPTH];
  rob_id_t     rob_d  [INTISQ_DEPTH];
  logic [INTISQ_DEPTH-1:0] b1_q, b1_d, b2_q, b2_d;
  cnt_t        count_q, count_d;

  logic       sel_found, issue_valid, fire, overflow, w0, w1;
  idx_t       sel_idx, idx0, idx1;
  cnt_t       free, count_c, room;
  logic [1:0] left;

  // A source stays busy unless a valid writeback this cycle carries its tag.
  function automatic logic still_busy(logic busy, prf_tag_t tag, logic v0, prf_tag_t t0,
                                      logic v1, prf_tag_t t1);
    return busy && !((v0 && (tag == t0)) || (v1 && (tag == t1)));
  endfunction

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = INTISQ_DEPTH - 1; i >= 0; i--) begin
      if ((cnt_t'(i) < count_q) && !b1_q[i] && !b2_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = idx_t'(i);
      end
    end
  end

  always_comb begin
    free = cnt_t'(INTISQ_DEPTH) - count_q;
    left = (free >= cnt_t'(2)) ? 2'd2 : free[1:0];
  end

  assign issue_valid       = sel_found && !bus.flush_valid;
  assign fire              = issue_valid && bus.issue_ready;
  assign bus.issue_valid   = issue_valid;
  assign bus.intisq_left   = left;
  assign bus.issue_control = issue_valid ? ctrl_q[sel_idx] : '0;
  assign bus.issue_T       = issue_valid ? t_q[sel_idx]    : '0;
  assign bus.issue_src1    = issue_valid ? s1_q[sel_idx]   : '0;
  assign bus.issue_src2    = issue_valid ? s2_q[sel_idx]   : '0;
  assign bus.issue_robid   = issue_valid ? rob_q[sel_idx]  : '0;
  assign overflow = !bus.flush_valid &&
                    (({1'b0, bus.instr0_valid_intisq} + {1'b0, bus.instr1_valid_intisq}) > left);

  always_comb begin
    logic shift;
    idx_t src;
    count_c = count_q - cnt_t'(fire);
    room    = cnt_t'(INTISQ_DEPTH) - count_c;
    w0      = bus.instr0_valid_intisq && !bus.flush_valid && (room != '0);
    w1      = bus.instr1_valid_intisq && !bus.flush_valid && (room > cnt_t'(w0));
    idx0    = count_c[IW-1:0];
    idx1    = idx0 + idx_t'(w0);
    // NOTE: every _d element is assigned by the collapse loop before any tail write, so no latches form.
    for (int i = 0; i < INTISQ_DEPTH; i++) begin
      shift     = fire && (idx_t'(i) >= sel_idx) && (i < INTISQ_DEPTH - 1);
      src       = idx_t'(i) + idx_t'(shift);
      ctrl_d[i] = ctrl_q[src];
      t_d[i]    = t_q[src];
      s1_d[i]   = s1_q[src];
      s2_d[i]   = s2_q[src];
      rob_d[i]  = rob_q[src];
      b1_d[i]   = still_busy(b1_q[src], s1_q[src], bus.wb0_valid, bus.wb0_tag,
                             bus.wb1_valid, bus.wb1_tag);
      b2_d[i]   = still_busy(b2_q[src], s2_q[src], bus.wb0_valid, bus.wb0_tag,
                             bus.wb1_valid, bus.wb1_tag);
    end
    if (w0) begin
      ctrl_d[idx0] = bus.instr0_control;
      t_d[idx0]    = bus.instr0_T;
      s1_d[idx0]   = bus.instr0_src1;
      s2_d[idx0]   = bus.instr0_src2;
      rob_d[idx0]  = bus.isq_robid_0;
      b1_d[idx0]   = still_busy(bus.isq_src1_busy_0, bus.instr0_src1, bus.wb0_valid,
                                bus.wb0_tag, bus.wb1_valid, bus.wb1_tag);
      b2_d[idx0]   = still_busy(bus.isq_src2_busy_0, bus.instr0_src2, bus.wb0_valid,
                                bus.wb0_tag, bus.wb1_valid, bus.wb1_tag);
    end
    if (w1) begin
      ctrl_d[idx1] = bus.instr1_control;
      t_d[idx1]    = bus.instr1_T;
      s1_d[idx1]   = bus.instr1_src1;
      s2_d[idx1]   = bus.instr1_src2;
      rob_d[idx1]  = bus.isq_robid_1;
      b1_d[idx1]   = still_busy(bus.isq_src1_busy_1, bus.instr1_src1, bus.wb0_valid,
                                bus.wb0_tag, bus.wb1_valid, bus.wb1_tag);
      b2_d[idx1]   = still_busy(bus.isq_src2_busy_1, bus.instr1_src2, bus.wb0_valid,
                                bus.wb0_tag, bus.wb1_valid, bus.wb1_tag);
    end
    count_d = bus.flush_valid ? '0 : count_c + cnt_t'(w0) + cnt_t'(w1);
  end

  // NOTE: only count_q is reset; entry payloads are meaningless beyond count_q, so they carry no reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    ctrl_q <= ctrl_d;
    t_q    <= t_d;
    s1_q   <= s1_d;
    s2_q   <= s2_d;
    rob_q  <= rob_d;
    b1_q   <= b1_d;
    b2_q   <= b2_d;
  end

  dispatch_within_left: assert property (@(posedge clk) disable iff (!reset_n) !overflow)
    else $warning("int_issue_queue: dispatch beyond intisq_left, excess writes dropped");
endmodule

// File: doc/int_issue_queue.md
INT_ISSUE_QUEUE -- requirements
Module: int_issue_queue

Interface
REQ-001 The block SHALL have parameter INTISQ_DEPTH, default 8, meaning number of entries (power of two, at least 4); PRF_WIDTH, ROB_WIDTH and control_type SHALL come from package common.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have ports instr0_valid_intisq and instr1_valid_intisq, input, 1 bit each, dispatch write enables (slot 0 older than slot 1).
REQ-005 The block SHALL have ports instr0_control and instr1_control, input, control_type, the dispatched control words.
REQ-006 The block SHALL have ports instr0_T and instr1_T, input, PRF_WIDTH, destination physical registers.
REQ-007 The block SHALL have ports instr0_src1, instr0_src2, instr1_src1 and instr1_src2, input, PRF_WIDTH, source physical registers.
REQ-008 The block SHALL have ports isq_src1_busy_0, isq_src2_busy_0, isq_src1_busy_1 and isq_src2_busy_1, input, 1 bit, source-not-ready flags.
REQ-009 The block SHALL have ports isq_robid_0 and isq_robid_1, input, ROB_WIDTH+1, ROB ids including the wrap bit.
REQ-010 The block SHALL have port intisq_left, output, 2 bits, free-entry count saturated at 2.
REQ-011 The block SHALL have ports wb0_valid and wb1_valid, input, 1 bit, wakeup broadcast valids.
REQ-012 The block SHALL have ports wb0_tag and wb1_tag, input, PRF_WIDTH, wakeup broadcast tags.
REQ-013 The block SHALL have port issue_ready, input, 1 bit, execute unit accepts an instruction this cycle.
REQ-014 The block SHALL have port issue_valid, output, 1 bit, an issuable instruction is presented.
REQ-015 The block SHALL have ports issue_control (control_type), issue_T, issue_src1, issue_src2 (PRF_WIDTH) and issue_robid (ROB_WIDTH+1), output, the fields of the issued entry.
REQ-016 The block SHALL have port flush_valid, input, 1 bit, pipeline flush.

Function
REQ-017 Storage SHALL be a collapsing queue in which entry 0 is oldest; the valid entries SHALL occupy indices 0..count-1 contiguously.
REQ-018 Each entry SHALL hold control, T, src1, src2, src1_busy, src2_busy and robid.
REQ-019 intisq_left SHALL equal min(INTISQ_DEPTH-count, 2), decoded from the registered count only, with no combinational input path.
REQ-020 Dispatch SHALL write to the tail after collapse: instr0 goes to the first free index; instr1 goes to the next index if instr0 is written, otherwise to the first free index.
REQ-021 If an incoming source tag equals a valid wb0 or wb1 tag in the same cycle, the written busy bit SHALL be 0.
REQ-022 Wakeup SHALL clear src1_busy/src2_busy of every valid entry whose tag matches wb0_tag or wb1_tag while the corresponding wbN_valid is 1; the update takes effect at the next edge.
REQ-023 Ready SHALL mean a valid entry with src1_busy=0 and src2_busy=0; issue_valid SHALL be 1 if any entry is ready, and the issue fields SHALL come from the lowest-index ready entry.
REQ-024 issue_valid SHALL NOT depend combinationally on issue_ready or any dispatch input; entries written this cycle SHALL become eligible no earlier than the next cycle.
REQ-025 On issue_valid and issue_ready both 1, the selected entry SHALL be removed at the edge and younger entries shift down by one, preserving order.
REQ-026 Issue and dispatch in the same cycle SHALL both take effect; the next count SHALL be count - issue + number of writes.
REQ-027 A wakeup in the same cycle as a shift SHALL apply to the shifted entry in its new position.
REQ-028 Dispatch exceeding intisq_left is a protocol violation; the block SHALL drop the excess writes, keep count at most INTISQ_DEPTH, and fire a simulation assertion.
REQ-029 flush_valid=1 SHALL invalidate all entries at the next edge, giving count=0, and SHALL ignore same-cycle dispatch and issue.
REQ-030 While flush_valid=1, issue_valid SHALL be 0.

Reset
REQ-031 While reset_n=0, all entry valids SHALL be 0, count SHALL be 0, intisq_left SHALL be 2, issue_valid SHALL be 0, and all issue fields SHALL be 0.
REQ-032 Reset assertion mid-operation SHALL clear state immediately, without waiting for a clock edge.
REQ-033 The first dispatch SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-034 The bench SHALL cover dual dispatch with all busy flags 0 into an empty queue -> cycle+1 issue_valid=1 with instr0 fields; with issue_ready=1, instr1 presented at cycle+2; intisq_left reads 2, then 2 (count 2 of 8).
REQ-035 The bench SHALL cover filling to 7 entries -> intisq_left=1; fill to 8 -> intisq_left=0; one issue -> intisq_left=1 next cycle.
REQ-036 The bench SHALL cover an entry with src1=5 busy, then wb0_valid=1 with tag 5 -> issue_valid=1 the next cycle; a dispatch carrying src tag 5 busy in the same cycle as wb tag 5 is written non-busy.
REQ-037 The bench SHALL cover an older entry blocked while a younger entry is ready -> the younger issues, the older remains at index 0, and order among the rest is preserved.
REQ-038 The bench SHALL cover a full queue with issue plus dual dispatch presented in the same cycle -> one dispatch kept, the excess dropped, the assertion fires, and count=8.
REQ-039 The bench SHALL cover flush_valid=1 with 5 entries plus a concurrent dispatch -> count=0, intisq_left=2, issue_valid=0 next cycle; reset_n pulsed low mid-operation -> outputs at reset values immediately.
